// File: rtl/maj_tree_pipe.sv
// Pipelined MAJ3 reduction tree: 3^LEVELS masked operands reduced to one WIDTH-bit word
// through LEVELS valid/ready stages. Define MAJ_TREE_STATS_EN to add the out_count port.
module maj_tree_pipe #(
   parameter int LEVELS = 2,
   parameter int WIDTH  = 4,
   localparam int N     = 3 ** LEVELS
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [N*WIDTH-1:0] in_data,
   input  logic [N-1:0]       inv_mask,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [WIDTH-1:0]   out_data
`ifdef MAJ_TREE_STATS_EN
   ,
   output logic [15:0]        out_count
`endif
);

   logic [N*WIDTH-1:0] maskedData;
   logic [LEVELS:1]    validVec;
   logic [LEVELS+1:1]  readyVec;

   for (genvar j = 0; j < N; j++) begin : mask
      assign maskedData[j*WIDTH +: WIDTH] = in_data[j*WIDTH +: WIDTH] ^ {WIDTH{inv_mask[j]}};
   end

   // A stage may load when it is empty or its successor is taking its current word.
   always_comb begin
      readyVec = '0;
      readyVec[LEVELS+1] = out_ready;
      for (int i = LEVELS; i >= 1; i--) begin
         readyVec[i] = !validVec[i] | readyVec[i+1];
      end
   end

   for (genvar s = 1; s <= LEVELS; s++) begin : stage
      localparam int NOUT = 3 ** (LEVELS - s);

      logic [3*NOUT*WIDTH-1:0] stIn;
      logic [NOUT*WIDTH-1:0]   stMaj;
      logic [NOUT*WIDTH-1:0]   stData;
      logic                    prevValid;
      logic                    vld;

      if (s == 1) begin : src
         assign stIn      = maskedData;
         assign prevValid = in_valid;
      end else begin : src
         assign stIn      = stage[s-1].stData;
         assign prevValid = validVec[s-1];
      end

      for (genvar k = 0; k < NOUT; k++) begin : grp
         logic [WIDTH-1:0] a, b, c;
         assign a = stIn[(3*k)*WIDTH   +: WIDTH];
         assign b = stIn[(3*k+1)*WIDTH +: WIDTH];
         assign c = stIn[(3*k+2)*WIDTH +: WIDTH];
         assign stMaj[k*WIDTH +: WIDTH] = (a & b) | (a & c) | (b & c);
      end

      // Loading a bubble simply clears the valid flag; a non-loading stage holds everything.
      always_ff @(posedge clk) begin
         if (rst) begin
            vld    <= 1'b0;
            stData <= '0;
         end else if (readyVec[s]) begin
            vld    <= prevValid;
            stData <= stMaj;
         end
      end

      assign validVec[s] = vld;
   end

   assign in_ready  = readyVec[1];
   assign out_valid = validVec[LEVELS];
   assign out_data  = stage[LEVELS].stData;

`ifdef MAJ_TREE_STATS_EN
   // Saturating count of output transfers.
   always_ff @(posedge clk) begin
      if (rst) begin
         out_count <= 16'h0000;
      end else if (out_valid && out_ready && (out_count != 16'hFFFF)) begin
         out_count <= out_count + 16'h0001;
      end
   end
`endif

endmodule
